fetch_sequencer: RTL and testbench

- Controller that sequences instruction fetch between the PC and a variable-latency instruction memory port using a valid/ready request and a valid response.
- Tracks the single outstanding request and buffers returned instructions in a 2-entry {pc, inst} FIFO toward decode.
- Applies branch/jump redirects with flush, and discards stale in-flight responses.

---
 rtl/fetch_sequencer.sv | 151 +++++++++++++++
 tb/tb_fetch_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Instruction fetch controller: issues one outstanding imem request at a time,
// buffers {pc, inst} pairs in a 2-entry FIFO toward decode, and handles redirects.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 2;
    localparam logic [CNT_W-1:0] FULL    = CNT_W'(BUF_DEPTH);
    localparam logic [XLEN-1:0]  PC_STEP = XLEN'(4);

    // DRAIN: a request is in flight whose response must be thrown away
    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [XLEN-1:0]  fetch_pc;
    logic [XLEN-1:0]  req_pc;
    logic [CNT_W-1:0] count;
    logic             rd_ptr;
    logic             wr_ptr;
    logic [XLEN-1:0]  buf_pc   [BUF_DEPTH];
    logic [XLEN-1:0]  buf_inst [BUF_DEPTH];

    logic accept;
    logic push;
    logic pop;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a redirect turns any in-flight request into one to drain
    always_comb begin
        state_next = state;
        case (state)
            S_FETCH: begin
                if (accept) begin
                    state_next = redirect_valid ? S_DRAIN : S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_resp_valid) begin
                    state_next = S_FETCH;
                end else if (redirect_valid) begin
                    state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (imem_resp_valid) begin
                    state_next = S_FETCH;
                end
            end
            default: state_next = S_FETCH;
        endcase
    end

    // Output and handshake decode
    always_comb begin
        imem_req_valid = 1'b0;
        imem_req_addr  = fetch_pc;
        out_valid      = 1'b0;
        out_pc         = buf_pc[rd_ptr];
        out_inst       = buf_inst[rd_ptr];
        accept         = 1'b0;
        push           = 1'b0;
        pop            = 1'b0;

        imem_req_valid = (state == S_FETCH) && (count < FULL) && !reset;
        accept         = imem_req_valid && imem_req_ready;
        out_valid      = (count != '0);
        push           = (state == S_WAIT) && imem_resp_valid && !redirect_valid;
        pop            = out_valid && out_ready && !redirect_valid;
    end

    // Fetch PC and the PC of the outstanding request; redirect wins over increment
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            req_pc   <= '0;
        end else begin
            if (redirect_valid) begin
                fetch_pc <= redirect_pc;
            end else if (accept) begin
                fetch_pc <= fetch_pc + PC_STEP;
            end
            if (accept) begin
                req_pc <= fetch_pc;
            end
        end
    end

    // FIFO occupancy and pointers; a redirect flushes and cancels push/pop
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count  <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else if (redirect_valid) begin
            count  <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // FIFO storage; contents are only meaningful where count says so
    always_ff @(posedge clk) begin
        if (push) begin
            buf_pc[wr_ptr]   <= req_pc;
            buf_inst[wr_ptr] <= imem_resp_data;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed cycle-table bench for fetch_sequencer, plus a streaming sequence
// against a variable-latency memory model with decode back-pressure.
module tb_fetch_sequencer;

    logic        clk;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_sequencer #(
        .RESET_PC  (32'h0000_0000),
        .BUF_DEPTH (2)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_pc          (out_pc),
        .out_inst        (out_inst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One row = one clock cycle: inputs driven in that cycle, outputs expected in that cycle
    typedef struct {
        logic        rst;
        logic        rdv;
        logic [31:0] rdpc;
        logic        rq_rdy;
        logic        rsp_v;
        logic [31:0] rsp_addr;
        logic        o_rdy;
        logic        e_req_v;
        logic [31:0] e_addr;
        logic        e_out_v;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'hA5A5_A5A5;
    endfunction

    function automatic vec_t v(input logic rst, input logic rdv, input logic [31:0] rdpc,
                               input logic rq, input logic rsv, input logic [31:0] rsa,
                               input logic ordy, input logic erv, input logic [31:0] ea,
                               input logic eov, input logic [31:0] ep);
        vec_t r;
        r.rst = rst; r.rdv = rdv; r.rdpc = rdpc; r.rq_rdy = rq; r.rsp_v = rsv;
        r.rsp_addr = rsa; r.o_rdy = ordy; r.e_req_v = erv; r.e_addr = ea;
        r.e_out_v = eov; r.e_pc = ep;
        return r;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [%0d]: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic fill_table();
        // basic 1-cycle-latency fetch with decode always ready
        vecs.push_back(v(1,0,0,0,0,0,0, 0,0,0,0));
        vecs.push_back(v(0,0,0,1,0,0,1, 1,0,0,0));
        vecs.push_back(v(0,0,0,1,1,0,1, 0,0,0,0));
        vecs.push_back(v(0,0,0,1,0,0,1, 1,4,1,0));
        vecs.push_back(v(0,0,0,1,1,4,1, 0,0,0,0));
        vecs.push_back(v(0,0,0,1,0,0,1, 1,8,1,4));
        vecs.push_back(v(0,0,0,1,1,8,1, 0,0,0,0));
        vecs.push_back(v(0,0,0,0,0,0,1, 1,32'hC,1,8));
        vecs.push_back(v(0,0,0,0,0,0,1, 1,32'hC,0,0));
        // decode stalled: buffer fills to 2 then issue stops
        vecs.push_back(v(1,0,0,0,0,0,0, 0,0,0,0));
        vecs.push_back(v(0,0,0,1,0,0,0, 1,0,0,0));
        vecs.push_back(v(0,0,0,1,1,0,0, 0,0,0,0));
        vecs.push_back(v(0,0,0,1,0,0,0, 1,4,1,0));
        vecs.push_back(v(0,0,0,1,1,4,0, 0,0,1,0));
        vecs.push_back(v(0,0,0,1,0,0,0, 0,0,1,0));
        vecs.push_back(v(0,0,0,1,0,0,1, 0,0,1,0));
        vecs.push_back(v(0,0,0,1,0,0,1, 1,8,1,4));
        vecs.push_back(v(0,0,0,1,1,8,1, 0,0,0,0));
        vecs.push_back(v(0,0,0,0,0,0,1, 1,32'hC,1,8));
        vecs.push_back(v(0,0,0,0,0,0,1, 1,32'hC,0,0));
        // redirect to 0x100 in WAIT for 0x8, response arrives 3 cycles later
        vecs.push_back(v(1,0,0,0,0,0,0, 0,0,0,0));
        vecs.push_back(v(0,0,0,1,0,0,1, 1,0,0,0));
        vecs.push_back(v(0,0,0,1,1,0,1, 0,0,0,0));
        vecs.push_back(v(0,0,0,1,0,0,1, 1,4,1,0));
        vecs.push_back(v(0,0,0,1,1,4,1, 0,0,0,0));
        vecs.push_back(v(0,0,0,1,0,0,1, 1,8,1,4));
        vecs.push_back(v(0,1,32'h100,1,0,0,1, 0,0,0,0));
        vecs.push_back(v(0,0,0,1,0,0,1, 0,0,0,0));
        vecs.push_back(v(0,0,0,1,0,0,1, 0,0,0,0));
        vecs.push_back(v(0,0,0,1,1,8,1, 0,0,0,0));
        vecs.push_back(v(0,0,0,1,0,0,1, 1,32'h100,0,0));
        vecs.push_back(v(0,0,0,1,1,32'h100,1, 0,0,0,0));
        vecs.push_back(v(0,0,0,0,0,0,1, 1,32'h104,1,32'h100));
        // redirect to 0x200 together with WAIT response and pop
        vecs.push_back(v(1,0,0,0,0,0,0, 0,0,0,0));
        vecs.push_back(v(0,0,0,1,0,0,0, 1,0,0,0));
        vecs.push_back(v(0,0,0,1,1,0,0, 0,0,0,0));
        vecs.push_back(v(0,0,0,1,0,0,0, 1,4,1,0));
        vecs.push_back(v(0,1,32'h200,1,1,4,1, 0,0,1,0));
        vecs.push_back(v(0,0,0,1,0,0,1, 1,32'h200,0,0));
        vecs.push_back(v(0,0,0,1,1,32'h200,1, 0,0,0,0));
        vecs.push_back(v(0,0,0,0,0,0,1, 1,32'h204,1,32'h200));
        vecs.push_back(v(0,0,0,0,0,0,1, 1,32'h204,0,0));
        // redirect in the same cycle 0x10 is accepted -> drain its response
        vecs.push_back(v(1,0,0,0,0,0,0, 0,0,0,0));
        vecs.push_back(v(0,1,32'h10,0,0,0,1, 1,0,0,0));
        vecs.push_back(v(0,1,32'h300,1,0,0,1, 1,32'h10,0,0));
        vecs.push_back(v(0,0,0,1,1,32'h10,1, 0,0,0,0));
        vecs.push_back(v(0,0,0,1,0,0,1, 1,32'h300,0,0));
        vecs.push_back(v(0,0,0,1,1,32'h300,1, 0,0,0,0));
        vecs.push_back(v(0,0,0,0,0,0,1, 1,32'h304,1,32'h300));
        vecs.push_back(v(0,0,0,0,0,0,1, 1,32'h304,0,0));
        // PC wrap, then reset asserted mid-WAIT with one entry buffered
        vecs.push_back(v(1,0,0,0,0,0,0, 0,0,0,0));
        vecs.push_back(v(0,1,32'hFFFF_FFFC,0,0,0,0, 1,0,0,0));
        vecs.push_back(v(0,0,0,1,0,0,0, 1,32'hFFFF_FFFC,0,0));
        vecs.push_back(v(0,0,0,1,1,32'hFFFF_FFFC,0, 0,0,0,0));
        vecs.push_back(v(0,0,0,1,0,0,0, 1,0,1,32'hFFFF_FFFC));
        vecs.push_back(v(1,0,0,0,0,0,0, 0,0,0,0));
        vecs.push_back(v(0,0,0,1,0,0,1, 1,0,0,0));
        vecs.push_back(v(0,0,0,1,1,0,1, 0,0,0,0));
        vecs.push_back(v(0,0,0,0,0,0,1, 1,4,1,0));
    endtask

    int          pend;
    int          got;
    logic        resp_now;
    logic [31:0] pend_addr;
    logic [31:0] exp_pc;

    initial begin
        reset           = 1'b1;
        redirect_valid  = 1'b0;
        redirect_pc     = '0;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        out_ready       = 1'b0;
        fill_table();
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            reset           = vecs[i].rst;
            redirect_valid  = vecs[i].rdv;
            redirect_pc     = vecs[i].rdpc;
            imem_req_ready  = vecs[i].rq_rdy;
            imem_resp_valid = vecs[i].rsp_v;
            imem_resp_data  = inst_of(vecs[i].rsp_addr);
            out_ready       = vecs[i].o_rdy;
            #1;
            check("req_valid", i, 32'(imem_req_valid), 32'(vecs[i].e_req_v));
            if (vecs[i].e_req_v) check("req_addr", i, imem_req_addr, vecs[i].e_addr);
            check("out_valid", i, 32'(out_valid), 32'(vecs[i].e_out_v));
            if (vecs[i].e_out_v) begin
                check("out_pc", i, out_pc, vecs[i].e_pc);
                check("out_inst", i, out_inst, inst_of(vecs[i].e_pc));
            end
            @(posedge clk);
            #1;
        end

        // streaming: random 1..3 cycle memory latency, random ready on both sides
        reset           = 1'b1;
        redirect_valid  = 1'b0;
        imem_resp_valid = 1'b0;
        @(posedge clk);
        #1;
        reset     = 1'b0;
        pend      = -1;
        got       = 0;
        pend_addr = '0;
        exp_pc    = '0;
        for (int cyc = 0; cyc < 400 && got < 12; cyc++) begin
            resp_now = 1'b0;
            if (pend > 0) begin
                pend--;
                resp_now = (pend == 0);
            end
            imem_resp_valid = resp_now;
            imem_resp_data  = inst_of(pend_addr);
            imem_req_ready  = 1'($urandom_range(0, 1));
            out_ready       = ($urandom_range(0, 3) != 0);
            #1;
            if (pend > 0 || resp_now) check("stream_single_outstanding", cyc, 32'(imem_req_valid), 32'd0);
            if (resp_now) pend = -1;
            if (out_valid && out_ready) begin
                check("stream_pc", got, out_pc, exp_pc);
                check("stream_inst", got, out_inst, inst_of(exp_pc));
                exp_pc = exp_pc + 32'd4;
                got++;
            end
            if (imem_req_valid && imem_req_ready) begin
                pend_addr = imem_req_addr;
                pend      = int'($urandom_range(1, 3));
            end
            @(posedge clk);
            #1;
        end
        check("stream_delivered", 0, 32'(got), 32'd12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
